// File: rtl/memory_access_ctrl.sv
// Purpose : initiator-side sequencer for a single-port cs/en memory; read/write requests in,
//           read data out, plus a self-timed sweep writing INIT_VALUE to every location.
// Latency : write reaches memory 1 cycle after acceptance; rsp_valid is high in the 3rd cycle after a read is accepted.
// Backpr. : one request in flight; req_ready is low outside IDLE; rsp_valid/rsp_rdata hold until rsp_ready.
//
// Ports
//   clk, rst_n                         clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready                request handshake; req_write selects write (1) or read (0)
//   req_addr, req_wdata                request address and write data, captured on acceptance
//   rsp_valid/rsp_ready, rsp_rdata     read response handshake and data
//   init_start, init_busy, init_done   sweep start (honoured in IDLE only), running flag, completion pulse
//   mem_cs, mem_en, mem_addr, mem_din  registered memory controls (en: 1 = write, 0 = read)
//   mem_q                              memory read data, valid while cs & ~en
module memory_access_ctrl #(
  parameter int                ADDR_W     = 4,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  output logic              mem_cs,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD1,
    S_RD2,
    S_RSP,
    S_INIT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              cs_nxt;
  logic              en_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] din_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              done_nxt;
  logic              accept;

  // init_start takes priority, so it masks req_ready in the same cycle.
  assign req_ready = (state == S_IDLE) && !init_start;
  assign accept    = req_valid && req_ready;
  assign init_busy = (state == S_INIT);

  // State register together with the registered memory/response outputs.
  // Every output register is loaded with the value belonging to the state
  // being entered, so the outputs line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mem_cs    <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_cs    <= cs_nxt;
      mem_en    <= en_nxt;
      mem_addr  <= addr_nxt;
      mem_din   <= din_nxt;
      rsp_valid <= (state_nxt == S_RSP);
      rsp_rdata <= rdata_nxt;
      init_done <= done_nxt;
    end
  end

  // Next-state and next-output logic. Defaults describe the quiet IDLE bus.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cs_nxt    = 1'b0;
    en_nxt    = 1'b0;
    addr_nxt  = '0;
    din_nxt   = '0;
    rdata_nxt = rsp_rdata;
    done_nxt  = 1'b0;

    case (state)
      S_IDLE: begin
        if (init_start) begin
          // First sweep cycle drives address cnt, which is 0 here.
          state_nxt = S_INIT;
          cs_nxt    = 1'b1;
          en_nxt    = 1'b1;
          addr_nxt  = cnt;
          din_nxt   = INIT_VALUE;
        end else if (accept) begin
          cs_nxt   = 1'b1;
          addr_nxt = req_addr;
          if (req_write) begin
            state_nxt = S_WR;
            en_nxt    = 1'b1;
            din_nxt   = req_wdata;
          end else begin
            state_nxt = S_RD1;
          end
        end
      end

      S_WR: begin
        state_nxt = S_IDLE;
      end

      S_RD1: begin
        // Memory loads its output register at the end of RD1; keep the
        // read selected through RD2 because mem_q is gated by cs & ~en.
        state_nxt = S_RD2;
        cs_nxt    = 1'b1;
        addr_nxt  = mem_addr;
      end

      S_RD2: begin
        state_nxt = S_RSP;
        rdata_nxt = mem_q;
      end

      S_RSP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end

      S_INIT: begin
        // mem_addr always equals cnt during the sweep; the counter wraps
        // back to 0 naturally after the last address.
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_ADDR) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else begin
          cs_nxt   = 1'b1;
          en_nxt   = 1'b1;
          addr_nxt = cnt + 1'b1;
          din_nxt  = INIT_VALUE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_access_ctrl.sv
module tb_memory_access_ctrl;

  localparam logic [7:0] INIT_V = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       init_start = 1'b0;
  logic       init_busy;
  logic       init_done;
  logic       mem_cs;
  logic       mem_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_q;

  memory_access_ctrl #(.ADDR_W(4), .DATA_W(8), .INIT_VALUE(INIT_V)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
    .mem_cs(mem_cs), .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Environment: single-port memory with a registered, cs & ~en gated output.
  logic [7:0] marr [16];
  logic [7:0] mq_reg;
  always @(posedge clk) begin
    if (mem_cs && mem_en) marr[mem_addr] <= mem_din;
    if (mem_cs && !mem_en) mq_reg <= marr[mem_addr];
  end
  assign mem_q = (mem_cs && !mem_en) ? mq_reg : 8'h00;

  // Reference model: what each address should hold.
  logic [7:0] ref_mem [16];
  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int cyc = 0;

  always @(negedge clk) if (rst_n && init_done) done_cnt <= done_cnt + 1;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [24:0] all_outs();
    return {mem_cs, mem_en, mem_addr, mem_din, rsp_valid, rsp_rdata, init_busy, init_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request driver: waits (bounded) for req_ready and returns one step after the accepting edge.
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int w = 0; w < 40 && !ok; w++) begin
      #1;
      ok = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, output bit ok);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    wait_accept(ok);
  endtask

  task automatic do_read(input logic [3:0] a, input int hold, output logic [7:0] got,
                         output int lat, output bit ok, output bit dropped);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; rsp_ready = 1'b0;
    wait_accept(ok);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    got = rsp_rdata;
    repeat (hold) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    dropped = !rsp_valid;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (all_outs() !== 25'd0) $display("FAIL reset_outs: got %h expected 0", all_outs());
    else n_pass++;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (all_outs() !== 25'd0) $display("FAIL post_reset_idle: got %h expected 0", all_outs());
    else n_pass++;
  endtask

  task automatic test_write_read();
    bit ok, dropped;
    logic [7:0] got;
    int lat;
    do_write(4'd3, 8'hA5, ok);
    n_checks++;
    if ({ok, mem_cs, mem_en, mem_addr, mem_din} !== {1'b1, 1'b1, 1'b1, 4'd3, 8'hA5})
      $display("FAIL wr_cycle: got ok=%b cs=%b en=%b addr=%h din=%h expected 1 1 1 3 a5",
               ok, mem_cs, mem_en, mem_addr, mem_din);
    else n_pass++;
    ref_mem[3] = 8'hA5;
    tick();
    n_checks++;
    if ({mem_cs, req_ready} !== 2'b01) $display("FAIL wr_done_idle: got cs/ready=%b expected 01", {mem_cs, req_ready});
    else n_pass++;
    do_read(4'd3, 0, got, lat, ok, dropped);
    n_checks++;
    if (lat !== 3) $display("FAIL rd_latency: got %0d expected 3", lat);
    else n_pass++;
    n_checks++;
    if (got !== ref_mem[3]) $display("FAIL rd_data: got %h expected %h", got, ref_mem[3]);
    else n_pass++;
    n_checks++;
    if ({ok, dropped} !== 2'b11) $display("FAIL rd_handshake: got ok/dropped=%b expected 11", {ok, dropped});
    else n_pass++;
  endtask

  task automatic test_rsp_backpressure();
    bit ok;
    int lat;
    do_write(4'd7, 8'h3C, ok);
    ref_mem[7] = 8'h3C;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd7; rsp_ready = 1'b0;
    wait_accept(ok);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    n_checks++;
    if ({ok, 5'(lat)} !== {1'b1, 5'd3}) $display("FAIL bp_latency: got ok=%b lat=%0d expected 1 3", ok, lat);
    else n_pass++;
    for (int h = 0; h < 5; h++) begin
      init_start = (h == 1);  // must be ignored outside IDLE
      #1;
      n_checks++;
      if ({rsp_valid, rsp_rdata, req_ready, mem_cs} !== {1'b1, 8'h3C, 1'b0, 1'b0})
        $display("FAIL bp_hold_%0d: got v=%b d=%h rdy=%b cs=%b expected 1 3c 0 0",
                 h, rsp_valid, rsp_rdata, req_ready, mem_cs);
      else n_pass++;
      tick();
    end
    init_start = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, req_ready, rsp_rdata} !== {1'b0, 1'b1, 8'h3C})
      $display("FAIL bp_release: got v=%b rdy=%b d=%h expected 0 1 3c", rsp_valid, req_ready, rsp_rdata);
    else n_pass++;
    tick();
    n_checks++;
    if ({init_busy, mem_cs} !== 2'b00) $display("FAIL init_ignored: got busy/cs=%b expected 00", {init_busy, mem_cs});
    else n_pass++;
  endtask

  task automatic test_init();
    bit ok, dropped;
    logic [7:0] got;
    int lat;
    int d0;
    logic [3:0] k4;
    d0 = done_cnt;
    init_start = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL init_masks_ready: got %b expected 0", req_ready);
    else n_pass++;
    tick();
    init_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      k4 = k[3:0];
      n_checks++;
      if ({mem_cs, mem_en, mem_addr, mem_din, init_busy, init_done} !== {1'b1, 1'b1, k4, INIT_V, 1'b1, 1'b0})
        $display("FAIL init_cycle_%0d: got cs=%b en=%b addr=%h din=%h busy=%b done=%b expected 1 1 %h %h 1 0",
                 k, mem_cs, mem_en, mem_addr, mem_din, init_busy, init_done, k4, INIT_V);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({init_done, init_busy, mem_cs} !== 3'b100)
      $display("FAIL init_end: got done/busy/cs=%b expected 100", {init_done, init_busy, mem_cs});
    else n_pass++;
    tick();
    n_checks++;
    if ({init_done, 8'(done_cnt - d0)} !== {1'b0, 8'd1})
      $display("FAIL init_done_pulse: got done=%b pulses=%0d expected 0 1", init_done, done_cnt - d0);
    else n_pass++;
    for (int i = 0; i < 16; i++) ref_mem[i] = INIT_V;
    do_read(4'd15, 0, got, lat, ok, dropped);
    n_checks++;
    if ({ok, got} !== {1'b1, ref_mem[15]}) $display("FAIL init_read15: got %h expected %h", got, ref_mem[15]);
    else n_pass++;
  endtask

  task automatic test_init_priority();
    int acc_n;
    logic done_seen;
    acc_n = -1;
    done_seen = 1'b0;
    init_start = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd2; req_wdata = 8'h77;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL prio_ready: got %b expected 0", req_ready);
    else n_pass++;
    tick();
    init_start = 1'b0;
    n_checks++;
    if ({init_busy, mem_addr} !== {1'b1, 4'd0}) $display("FAIL prio_sweep_first: got busy=%b addr=%h expected 1 0", init_busy, mem_addr);
    else n_pass++;
    for (int n = 0; n < 40 && acc_n < 0; n++) begin
      #1;
      if (req_ready) begin
        acc_n = n;
        done_seen = init_done;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    n_checks++;
    if ({8'(acc_n), done_seen} !== {8'd16, 1'b1})
      $display("FAIL prio_accept_time: got cycle=%0d done=%b expected 16 1", acc_n, done_seen);
    else n_pass++;
    n_checks++;
    if ({mem_cs, mem_en, mem_addr, mem_din} !== {1'b1, 1'b1, 4'd2, 8'h77})
      $display("FAIL prio_write: got cs=%b en=%b addr=%h din=%h expected 1 1 2 77", mem_cs, mem_en, mem_addr, mem_din);
    else n_pass++;
    for (int i = 0; i < 16; i++) ref_mem[i] = INIT_V;
    ref_mem[2] = 8'h77;
    tick();
  endtask

  task automatic test_reset_abort();
    bit ok, dropped;
    logic [7:0] got;
    int lat, vcount, d0;
    do_write(4'd4, 8'h5A, ok);
    ref_mem[4] = 8'h5A;
    do_read(4'd4, 0, got, lat, ok, dropped);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd4; rsp_ready = 1'b1;
    wait_accept(ok);
    tick();
    n_checks++;
    if ({ok, mem_cs, mem_en, rsp_valid, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h5A})
      $display("FAIL abort_rd2_setup: got ok=%b cs=%b en=%b v=%b d=%h expected 1 1 0 0 5a",
               ok, mem_cs, mem_en, rsp_valid, rsp_rdata);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== 25'd0) $display("FAIL abort_rd2_outs: got %h expected 0", all_outs());
    else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL abort_rd2_ready: got %b expected 1", req_ready);
    else n_pass++;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid) vcount++;
    end
    rsp_ready = 1'b0;
    n_checks++;
    if (vcount !== 0) $display("FAIL abort_rd2_no_rsp: got %0d valid cycles expected 0", vcount);
    else n_pass++;

    d0 = done_cnt;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int i = 0; i < 20 && mem_addr != 4'd9; i++) tick();
    n_checks++;
    if ({init_busy, mem_addr} !== {1'b1, 4'd9}) $display("FAIL abort_init_reach9: got busy=%b addr=%h expected 1 9", init_busy, mem_addr);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== 25'd0) $display("FAIL abort_init_outs: got %h expected 0", all_outs());
    else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL abort_init_ready: got %b expected 1", req_ready);
    else n_pass++;
    repeat (20) tick();
    n_checks++;
    if ({init_busy, 8'(done_cnt - d0)} !== {1'b0, 8'd0})
      $display("FAIL abort_init_no_done: got busy=%b pulses=%0d expected 0 0", init_busy, done_cnt - d0);
    else n_pass++;
    for (int i = 0; i < 9; i++) ref_mem[i] = INIT_V;
  endtask

  task automatic test_back_to_back();
    bit ok, dropped;
    logic [7:0] got, d;
    int lat, last_cyc, bad_gaps, bad_rd;
    bad_gaps = 0;
    last_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      do_write(i[3:0], d, ok);
      if (!ok) bad_gaps++;
      ref_mem[i] = d;
      if (i > 0 && (cyc - last_cyc) != 2) bad_gaps++;
      last_cyc = cyc;
    end
    n_checks++;
    if (bad_gaps !== 0) $display("FAIL b2b_write_rate: got %0d bad acceptances expected 0", bad_gaps);
    else n_pass++;
    tick();
    bad_rd = 0;
    for (int i = 0; i < 16; i++) begin
      do_read(i[3:0], $urandom_range(0, 3), got, lat, ok, dropped);
      n_checks++;
      if ({ok, 5'(lat), got, dropped} !== {1'b1, 5'd3, ref_mem[i], 1'b1}) begin
        $display("FAIL b2b_read_%0d: got ok=%b lat=%0d data=%h dropped=%b expected 1 3 %h 1",
                 i, ok, lat, got, dropped, ref_mem[i]);
        bad_rd++;
      end else n_pass++;
    end
  endtask

  task automatic test_random();
    bit ok, dropped;
    logic [7:0] got, d;
    logic [3:0] a;
    int lat;
    for (int i = 0; i < 60; i++) begin
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        do_write(a, d, ok);
        ref_mem[a] = d;
        n_checks++;
        if ({ok, mem_cs, mem_en, mem_addr, mem_din} !== {1'b1, 1'b1, 1'b1, a, d})
          $display("FAIL rand_write_%0d: got ok=%b cs=%b en=%b addr=%h din=%h expected 1 1 1 %h %h",
                   i, ok, mem_cs, mem_en, mem_addr, mem_din, a, d);
        else n_pass++;
      end else begin
        do_read(a, $urandom_range(0, 2), got, lat, ok, dropped);
        n_checks++;
        if ({ok, 5'(lat), got, dropped} !== {1'b1, 5'd3, ref_mem[a], 1'b1})
          $display("FAIL rand_read_%0d: got ok=%b lat=%0d data=%h dropped=%b expected 1 3 %h 1",
                   i, ok, lat, got, dropped, ref_mem[a]);
        else n_pass++;
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_write_read();
    test_rsp_backpressure();
    test_init();
    test_init_priority();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
